register_bank_p: RTL

Parametrised, clocked successor to the combinational register bank. It holds 2^ADDR_W registers of DATA_W bits and provides two registered read ports and one write port with read-during-write bypass. A per-register pending scoreboard lets the pipeline control detect RAW hazards, and a post-reset clear sweep zeroes the array. It sits between decode (RA/RB/RSV) and writeback (WC/WPC/W_RB) in the datapath.

---
 rtl/register_bank_p_if.sv | 29 ++
 rtl/register_bank_p.sv | 119 +++++++++++
 2 files changed

// File: rtl/register_bank_p_if.sv
// Bus bundle between decode/writeback and the register bank.
// The bank side uses the slave modport, the pipeline control side uses master.
interface register_bank_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [ADDR_W-1:0] WC;
    logic [DATA_W-1:0] WPC;
    logic              W_RB;
    logic              RSV_EN;
    logic [ADDR_W-1:0] RSV_ADDR;
    logic [DATA_W-1:0] PRA;
    logic [DATA_W-1:0] PRB;
    logic              PEND_A;
    logic              PEND_B;
    logic              READY;

    modport master (
        output RA, RB, WC, WPC, W_RB, RSV_EN, RSV_ADDR,
        input  PRA, PRB, PEND_A, PEND_B, READY
    );

    modport slave (
        input  RA, RB, WC, WPC, W_RB, RSV_EN, RSV_ADDR,
        output PRA, PRB, PEND_A, PEND_B, READY
    );
endinterface

// File: rtl/register_bank_p.sv
// Clocked register bank: two registered read ports with write bypass, one
// write port, a per-register pending scoreboard and a post-reset clear sweep.
module register_bank_p #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    register_bank_p_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] r_pra;
    logic [DATA_W-1:0] r_prb;
    logic              r_pend_a;
    logic              r_pend_b;
    logic              r_ready;

    logic              w_wr_en;
    logic              w_rsv_en;
    logic [DEPTH-1:0]  w_pend_next;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_pd_a;
    logic              w_pd_b;

    // With ZERO_R0 the hardwired register silently drops writes and reserves.
    assign w_wr_en  = bus.W_RB   && !(ZERO_R0 && (bus.WC == '0));
    assign w_rsv_en = bus.RSV_EN && !(ZERO_R0 && (bus.RSV_ADDR == '0));

    // Scoreboard after this cycle's write-clear then reserve-set (reserve wins).
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr_en)
            w_pend_next[bus.WC] = 1'b0;
        if (w_rsv_en)
            w_pend_next[bus.RSV_ADDR] = 1'b1;
    end

    // Port A read value: forced zero for r0, else bypassed write data or array.
    always_comb begin
        w_rd_a = r_mem[bus.RA];
        w_pd_a = w_pend_next[bus.RA];
        if (ZERO_R0 && (bus.RA == '0)) begin
            w_rd_a = '0;
            w_pd_a = 1'b0;
        end else if (w_wr_en && (bus.WC == bus.RA)) begin
            w_rd_a = bus.WPC;
        end
    end

    // Port B read value: same rule as port A.
    always_comb begin
        w_rd_b = r_mem[bus.RB];
        w_pd_b = w_pend_next[bus.RB];
        if (ZERO_R0 && (bus.RB == '0)) begin
            w_rd_b = '0;
            w_pd_b = 1'b0;
        end else if (w_wr_en && (bus.WC == bus.RB)) begin
            w_rd_b = bus.WPC;
        end
    end

    // Register array: the sweep zeroes one entry per edge, then normal writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR)
                r_mem[r_cnt] <= '0;
            else if (w_wr_en)
                r_mem[bus.WC] <= bus.WPC;
        end
    end

    // Sweep sequencing, scoreboard and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_pra    <= '0;
            r_prb    <= '0;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_pend[r_cnt] <= 1'b0;
            r_pra         <= '0;
            r_prb         <= '0;
            r_pend_a      <= 1'b0;
            r_pend_b      <= 1'b0;
            if (r_cnt == LAST) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_pend   <= w_pend_next;
            r_pra    <= w_rd_a;
            r_prb    <= w_rd_b;
            r_pend_a <= w_pd_a;
            r_pend_b <= w_pd_b;
        end
    end

    assign bus.PRA    = r_pra;
    assign bus.PRB    = r_prb;
    assign bus.PEND_A = r_pend_a;
    assign bus.PEND_B = r_pend_b;
    assign bus.READY  = r_ready;
endmodule
